// File: rtl/read_write_ram_pkg.sv
// Shared types and default widths for the read-modify-write engine and its RAM.
package read_write_ram_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 5;
    localparam int unsigned DATA_WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        WRITE,
        DONE
    } state_e;

endpackage

// File: rtl/read_write_ram_if.sv
// Request/completion handshake plus port-0 RAM signals between the engine and a 1R1W RAM.
interface read_write_ram_if #(
    parameter int unsigned ADDR_WIDTH = read_write_ram_pkg::ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = read_write_ram_pkg::DATA_WIDTH_DEF
);
    logic                  start;
    logic                  ready;
    logic                  done;
    logic [ADDR_WIDTH-1:0] ram_raddr_0;
    logic [DATA_WIDTH-1:0] ram_rdata_0;
    logic [ADDR_WIDTH-1:0] ram_waddr_0;
    logic                  ram_wen_0;
    logic [DATA_WIDTH-1:0] ram_wdata_0;

    // Engine side
    modport master (
        input  start,
        input  ram_rdata_0,
        output ready,
        output done,
        output ram_raddr_0,
        output ram_waddr_0,
        output ram_wen_0,
        output ram_wdata_0
    );

    // RAM side
    modport slave (
        input  ram_raddr_0,
        output ram_rdata_0,
        input  ram_waddr_0,
        input  ram_wen_0,
        input  ram_wdata_0
    );

endinterface

// File: rtl/read_write_ram_ram_1r1w.sv
// One-read/one-write synchronous RAM; read of the word being written returns old data.
module ram_1r1w #(
    parameter int unsigned ADDR_WIDTH = read_write_ram_pkg::ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = read_write_ram_pkg::DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic                  wen_i,
    input  logic [DATA_WIDTH-1:0] wdata_i
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Array contents survive reset
    always_ff @(posedge clk) begin
        if (wen_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/read_write_ram.sv
// Single-shot engine: reads SRC_ADDR, adds INCREMENT, writes DST_ADDR, then reports done.
module read_write_ram
    import read_write_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned SRC_ADDR   = 0,
    parameter int unsigned DST_ADDR   = 1,
    parameter int unsigned INCREMENT  = 1
) (
    input logic                clk,
    input logic                rst,
    read_write_ram_if.master   bus
);
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  ready_q, ready_d;
    logic                  done_q,  done_d;
    logic                  wen_q,   wen_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            wen_q   <= wen_d;
        end
    end

    // Handshake flags are decoded from the next state so they register alongside it
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ready_d = 1'b0;
        done_d  = 1'b0;
        wen_d   = 1'b0;

        case (state_q)
            IDLE:    if (bus.start) state_d = READ;
            READ:    state_d = CAPTURE;
            CAPTURE: begin
                data_d  = bus.ram_rdata_0 + DATA_WIDTH'(INCREMENT);
                state_d = WRITE;
            end
            WRITE:   state_d = DONE;
            DONE:    if (bus.start) state_d = READ;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE) || (state_d == DONE);
        done_d  = (state_d == DONE);
        wen_d   = (state_d == WRITE);
    end

    assign bus.ready       = ready_q;
    assign bus.done        = done_q;
    assign bus.ram_wen_0   = wen_q;
    assign bus.ram_wdata_0 = data_q;
    assign bus.ram_raddr_0 = ADDR_WIDTH'(SRC_ADDR);
    assign bus.ram_waddr_0 = ADDR_WIDTH'(DST_ADDR);

endmodule

// File: tb/tb_read_write_ram.sv
// Randomized scoreboard bench: two engines (distinct and shared src/dst) beside their RAMs.
module tb_read_write_ram;
    import read_write_ram_pkg::*;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam logic [AW-1:0] SRC_A = 5'd0;
    localparam logic [AW-1:0] DST_A = 5'd1;
    localparam logic [AW-1:0] SRC_B = 5'd0;
    localparam logic [AW-1:0] DST_B = 5'd0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          start_s [2] = '{1'b0, 1'b0};
    logic          ld_en   [2] = '{1'b0, 1'b0};
    logic [AW-1:0] ld_addr [2] = '{5'd0, 5'd0};
    logic [DW-1:0] ld_data [2] = '{32'd0, 32'd0};

    // Reference model: op = (mem[src] + 1) mod 2^32 into mem[dst], finishing 3 edges after acceptance
    int            busy   [2] = '{0, 0};
    bit            done_m [2] = '{1'b0, 1'b0};
    logic [DW-1:0] pend   [2];
    logic [DW-1:0] mem_m  [2][32];
    exp_t          q_a [$];
    exp_t          q_b [$];

    int checks  = 0;
    int errors  = 0;
    bit mon_en  = 1'b1;
    bit mem_chk = 1'b0;

    read_write_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
    read_write_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

    assign bus_a.start = start_s[0];
    assign bus_b.start = start_s[1];

    read_write_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRC_ADDR(0), .DST_ADDR(1), .INCREMENT(1))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    read_write_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRC_ADDR(0), .DST_ADDR(0), .INCREMENT(1))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    ram_1r1w #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram_a (
        .clk(clk), .rst(rst),
        .raddr_i(bus_a.ram_raddr_0), .rdata_o(bus_a.ram_rdata_0),
        .waddr_i(ld_en[0] ? ld_addr[0] : bus_a.ram_waddr_0),
        .wen_i(ld_en[0] | bus_a.ram_wen_0),
        .wdata_i(ld_en[0] ? ld_data[0] : bus_a.ram_wdata_0)
    );
    ram_1r1w #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram_b (
        .clk(clk), .rst(rst),
        .raddr_i(bus_b.ram_raddr_0), .rdata_o(bus_b.ram_rdata_0),
        .waddr_i(ld_en[1] ? ld_addr[1] : bus_b.ram_waddr_0),
        .wen_i(ld_en[1] | bus_b.ram_wen_0),
        .wdata_i(ld_en[1] ? ld_data[1] : bus_b.ram_wdata_0)
    );

    function automatic logic [AW-1:0] src_of(input int g);
        return (g == 0) ? SRC_A : SRC_B;
    endfunction

    function automatic logic [AW-1:0] dst_of(input int g);
        return (g == 0) ? DST_A : DST_B;
    endfunction

    task automatic model_step();
        exp_t e;
        if (!rst) return;
        for (int g = 0; g < 2; g++) begin
            if (ld_en[g]) mem_m[g][ld_addr[g]] = ld_data[g];
            if (busy[g] > 0) begin
                busy[g]--;
                if (busy[g] == 0) begin
                    mem_m[g][dst_of(g)] = pend[g];
                    done_m[g] = 1'b1;
                end
            end else if (start_s[g]) begin
                pend[g]   = mem_m[g][src_of(g)] + 32'd1;
                busy[g]   = 3;
                done_m[g] = 1'b0;
                e.addr = dst_of(g);
                e.data = pend[g];
                if (g == 0) q_a.push_back(e); else q_b.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic load(input int g, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_en[g] = 1'b1; ld_addr[g] = a; ld_data[g] = d;
        tick();
        ld_en[g] = 1'b0;
    endtask

    task automatic pulse(input int g);
        start_s[g] = 1'b1;
        tick();
        start_s[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        for (int i = 0; i < 10 && busy[g] != 0; i++) tick();
    endtask

    task automatic chk(input string name, input int g, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got %h want %h", name, g, $time, act, exp);
        end
    endtask

    task automatic check_inst(input int g, input logic rdy, input logic dn, input logic wen,
                              input logic [AW-1:0] raddr, input logic [AW-1:0] waddr,
                              input logic [DW-1:0] wdata, input logic [DW-1:0] msrc,
                              input logic [DW-1:0] mdst);
        exp_t e;
        int   qs;
        chk("ready", g, 32'(rdy), 32'(busy[g] == 0));
        chk("done",  g, 32'(dn),  32'(done_m[g]));
        chk("wen",   g, 32'(wen), 32'(busy[g] == 1));
        chk("raddr", g, 32'(raddr), 32'(src_of(g)));
        if (wen === 1'b1) begin
            qs = (g == 0) ? q_a.size() : q_b.size();
            if (qs == 0) begin
                chk("wen_unexpected", g, 32'd1, 32'd0);
            end else begin
                e = (g == 0) ? q_a.pop_front() : q_b.pop_front();
                chk("waddr", g, 32'(waddr), 32'(e.addr));
                chk("wdata", g, wdata, e.data);
            end
        end
        if (busy[g] == 0) begin
            qs = (g == 0) ? q_a.size() : q_b.size();
            chk("missed_write", g, 32'(qs), 32'd0);
            if (mem_chk) begin
                chk("mem_src", g, msrc, mem_m[g][src_of(g)]);
                chk("mem_dst", g, mdst, mem_m[g][dst_of(g)]);
            end
        end
    endtask

    // Monitor: compares every DUT output against the model away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            check_inst(0, bus_a.ready, bus_a.done, bus_a.ram_wen_0, bus_a.ram_raddr_0,
                       bus_a.ram_waddr_0, bus_a.ram_wdata_0, ram_a.mem_q[SRC_A], ram_a.mem_q[DST_A]);
            check_inst(1, bus_b.ready, bus_b.done, bus_b.ram_wen_0, bus_b.ram_raddr_0,
                       bus_b.ram_waddr_0, bus_b.ram_wdata_0, ram_b.mem_q[SRC_B], ram_b.mem_q[DST_B]);
        end
    end

    initial begin
        repeat (3) tick();
        rst = 1'b1;
        tick();

        for (int g = 0; g < 2; g++)
            for (int a = 0; a < 4; a++) load(g, AW'(a), $urandom);
        mem_chk = 1'b1;

        // Basic operation and wrap-around
        load(0, SRC_A, 32'h0000_0010);
        pulse(0);
        wait_idle(0);
        tick();
        load(0, SRC_A, 32'hFFFF_FFFF);
        pulse(0);
        wait_idle(0);
        tick();

        // Start held through busy cycles, relaunching from DONE
        load(0, SRC_A, 32'h0000_1234);
        start_s[0] = 1'b1;
        repeat (9) tick();
        start_s[0] = 1'b0;
        wait_idle(0);
        tick();

        // In-place increments back to back
        load(1, SRC_B, 32'd5);
        pulse(1);
        wait_idle(1);
        tick();
        pulse(1);
        wait_idle(1);
        tick();

        // Reset while the read data is being captured
        load(0, SRC_A, 32'hCAFE_0000);
        pulse(0);
        tick();
        rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            busy[g]   = 0;
            done_m[g] = 1'b0;
        end
        q_a.delete();
        q_b.delete();
        #6;
        rst = 1'b1;
        tick();
        pulse(0);
        wait_idle(0);
        tick();

        // Random traffic on both engines
        repeat (300) begin
            for (int g = 0; g < 2; g++) begin
                ld_en[g] = 1'b0;
                if (busy[g] == 0 && $urandom_range(0, 3) == 0) begin
                    ld_en[g]   = 1'b1;
                    ld_addr[g] = AW'($urandom_range(0, 3));
                    ld_data[g] = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
                end
                start_s[g] = ($urandom_range(0, 2) == 0);
            end
            tick();
        end
        for (int g = 0; g < 2; g++) begin
            ld_en[g]   = 1'b0;
            start_s[g] = 1'b0;
        end
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/read_write_ram.md
Name: read_write_ram

Overview:
- Single-shot RAM read-modify-write engine.
- On a start request it reads one word from a fixed source address of an external single-port-pair RAM (one read port, one write port). It adds a constant and writes the result to a fixed destination address.
- It signals completion with a ready/done handshake.
- Sits beside a RAM instance; the RAM ports connect directly, port 0 of each.

Parameters:
- ADDR_WIDTH, 5, RAM address width.
- DATA_WIDTH, 32, RAM word width.
- SRC_ADDR, 0, address read by the operation.
- DST_ADDR, 1, address written by the operation.
- INCREMENT, 1, constant added to the read word.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  operation request; sampled on a rising edge only while ready=1.
- ready  out  1  high when idle or done; a new start may be accepted.
- done  out  1  high once the write has committed; held until the next accepted start.
- ram_raddr_0  out  ADDR_WIDTH  RAM read address.
- ram_rdata_0  in  DATA_WIDTH  RAM read data; the RAM registers it, so it is valid one cycle after raddr is presented.
- ram_waddr_0  out  ADDR_WIDTH  RAM write address.
- ram_wen_0  out  1  RAM write enable; the RAM writes on the rising edge where it is 1.
- ram_wdata_0  out  DATA_WIDTH  RAM write data.

Behaviour:
- States: IDLE, READ, CAPTURE, WRITE, DONE. The state register is reset asynchronously to IDLE while rst=0.
- Reset values:
  - ready=1, done=0, ram_wen_0=0.
  - ram_raddr_0=SRC_ADDR, ram_waddr_0=DST_ADDR.
  - ram_wdata_0=0 (data register cleared).
- IDLE: ready=1, done=0. If start=1 at an edge (call it E0), go to READ; otherwise stay.
- READ: ready=0. ram_raddr_0=SRC_ADDR (the address is held constant in all states). At edge E1, go to CAPTURE; the RAM latches rdata at the same edge.
- CAPTURE: ready=0. At E2: data_q <= ram_rdata_0 + INCREMENT, modulo 2^DATA_WIDTH (wraps, no carry out). Go to WRITE.
- WRITE: ready=0, ram_wen_0=1, ram_waddr_0=DST_ADDR, ram_wdata_0=data_q. At E3 the RAM commits the write; go to DONE.
- DONE: ready=1, done=1, ram_wen_0=0.
  - start=1 at an edge: go to READ and drop done next cycle.
  - Otherwise stay in DONE.
- Latency: done=1 and ready=1 after the 4th rising edge counting the start-sampling edge E0, i.e. 3 edges after E0. ready=0 during READ, CAPTURE and WRITE.
- start asserted while ready=0 is ignored; it is neither queued nor an error.
- ram_wen_0 is high for exactly one cycle per operation. It is never high outside WRITE.
- Reset mid-operation: immediate return to IDLE and wen drops asynchronously. A write in progress is abandoned if reset is asserted before the write edge.
- SRC_ADDR == DST_ADDR is allowed: the word is incremented in place.
- All outputs are decoded from registered state or registers only; there are no combinational paths from start.
- Companion RAM model (for bench/integration):
  - 2^ADDR_WIDTH x DATA_WIDTH.
  - Synchronous read: rdata registered from raddr each edge.
  - Synchronous write when wen=1.
  - Read of the address being written returns old data.
  - Contents are not cleared by reset; rdata is reset to 0.

Decomposition:
- Shared package: state enum (IDLE, READ, CAPTURE, WRITE, DONE), default ADDR_WIDTH/DATA_WIDTH constants.
- One sub-module is natural: ram_1r1w, the RAM model above, used by the bench and integration. The engine itself is a single FSM module.

Test Plan:
- Reset: rst=0 then release, one clock -> ready=1, done=0, ram_wen_0=0.
- Basic op: preload mem[0]=0x0000_0010, pulse start one cycle.
  - ready=0 after E0 and after E1.
  - ram_wen_0=1 with waddr=1, wdata=0x11 in the cycle after E2.
  - After E3: done=1, ready=1, mem[1]=0x11.
- Wrap: mem[0]=0xFFFF_FFFF -> mem[1]=0x0000_0000, done=1 after 3 edges.
- Start ignored while busy: start held high through the operation -> exactly one wen pulse. After done, the held start launches a second op (done drops the cycle after).
- Back-to-back: set SRC=DST=0, mem[0]=5, two starts each after done -> mem[0]=7, done=1 after each op.
- Reset mid-op: assert rst=0 during CAPTURE -> ready=1, done=0, wen=0 immediately. mem[1] is unchanged. A subsequent start completes normally.
